// File: rtl/reg_slice_pipe.sv
// Multi-stage valid/ready register slice with pass-through, forward-only and
// full (registered ready + skid) modes, plus a registered occupancy count.
module reg_slice_pipe #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned STAGES     = 1,
    parameter int unsigned MODE       = 2,
    parameter int unsigned CNT_WIDTH  = $clog2(2 * STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    if (MODE == 0) begin : g_pass
        // Plain wires; the clock is not needed in this mode.
        logic unused_clk;
        assign unused_clk = clk;

        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready & ~reset;
        assign occupancy = '0;

    end else if (MODE == 1) begin : g_fwd
        logic [STAGES-1:0]     valid_q;
        logic [STAGES-1:0]     valid_in;
        logic [STAGES-1:0]     rdy;
        logic [DATA_WIDTH-1:0] data_q  [STAGES];
        logic [DATA_WIDTH-1:0] data_in [STAGES];

        // Stage s feeds from stage s-1, stage 0 from the upstream port.
        assign valid_in = STAGES'({valid_q, in_valid});

        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            // A stage may load if downstream takes a beat or any later stage holds a bubble.
            assign rdy[s] = out_ready | ~(&valid_q[STAGES-1:s]);
            if (s == 0) begin : g_head
                assign data_in[s] = in_data;
            end else begin : g_body
                assign data_in[s] = data_q[s-1];
            end
        end

        // Valid flags advance wherever the stage is ready.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= '0;
            end else begin
                valid_q <= (rdy & valid_in) | (~rdy & valid_q);
            end
        end

        // Data registers follow the same load enables and carry no reset.
        always_ff @(posedge clk) begin
            for (int s = 0; s < STAGES; s++) begin
                if (rdy[s]) begin
                    data_q[s] <= data_in[s];
                end
            end
        end

        assign in_ready  = rdy[0] & ~reset;
        assign out_valid = valid_q[STAGES-1];
        assign out_data  = data_q[STAGES-1];

    end else begin : g_full
        logic [STAGES-1:0]     main_valid;
        logic [STAGES-1:0]     skid_valid;
        logic [STAGES-1:0]     ready_q;
        logic [STAGES-1:0]     valid_in;
        logic [STAGES-1:0]     dn_rdy;
        logic [STAGES-1:0]     accept;
        logic [STAGES-1:0]     main_free;
        logic [STAGES-1:0]     main_load;
        logic [STAGES-1:0]     skid_load;
        logic [STAGES-1:0]     main_valid_n;
        logic [STAGES-1:0]     skid_valid_n;
        logic [DATA_WIDTH-1:0] main_data [STAGES];
        logic [DATA_WIDTH-1:0] skid_data [STAGES];
        logic [DATA_WIDTH-1:0] data_in   [STAGES];

        // Upstream valid per stage, and the registered ready of the next stage.
        assign valid_in = STAGES'({main_valid, in_valid});
        assign dn_rdy   = STAGES'({out_ready, ready_q} >> 1);

        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_head
                assign data_in[s] = in_data;
            end else begin : g_body
                assign data_in[s] = main_data[s-1];
            end
        end

        // Main is free when empty or emitting; skid refills main before new input does.
        assign accept       = valid_in & ready_q;
        assign main_free    = ~main_valid | (main_valid & dn_rdy);
        assign main_load    = main_free & (skid_valid | accept);
        assign skid_load    = ~main_free & accept;
        assign main_valid_n = ~main_free | skid_valid | accept;
        assign skid_valid_n = (skid_valid | accept) & ~main_free;

        // Valid flags and registered ready; ready stays low until the first edge out of reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                main_valid <= '0;
                skid_valid <= '0;
                ready_q    <= '0;
            end else begin
                main_valid <= main_valid_n;
                skid_valid <= skid_valid_n;
                ready_q    <= ~skid_valid_n;
            end
        end

        // Main and skid data registers; no reset on the data path.
        always_ff @(posedge clk) begin
            for (int s = 0; s < STAGES; s++) begin
                if (main_load[s]) begin
                    main_data[s] <= skid_valid[s] ? skid_data[s] : data_in[s];
                end
                if (skid_load[s]) begin
                    skid_data[s] <= data_in[s];
                end
            end
        end

        assign in_ready  = ready_q[0] & ~reset;
        assign out_valid = main_valid[STAGES-1];
        assign out_data  = main_data[STAGES-1];
    end

    if (MODE != 0) begin : g_occ
        logic                 in_fire;
        logic                 out_fire;
        logic [CNT_WIDTH-1:0] occ_q;

        assign in_fire   = in_valid & in_ready;
        assign out_fire  = out_valid & out_ready;
        assign occupancy = occ_q;

        // Beat count: +1 on accept, -1 on emit, unchanged when both happen.
        always_ff @(posedge clk) begin
            if (reset) begin
                occ_q <= '0;
            end else if (in_fire && !out_fire) begin
                occ_q <= occ_q + CNT_WIDTH'(1);
            end else if (!in_fire && out_fire) begin
                occ_q <= occ_q - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_slice_pipe.sv
// Bench for reg_slice_pipe: five instances in different modes/depths share one
// clock; a scoreboard monitor checks ordering, occupancy and stall stability.
module tb_reg_slice_pipe;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int          NI = 5;

    logic          clk = 1'b0;
    logic          rst       [NI];
    logic [DW-1:0] in_data   [NI];
    logic          in_valid  [NI];
    logic          in_ready  [NI];
    logic [DW-1:0] out_data  [NI];
    logic          out_valid [NI];
    logic          out_ready [NI];
    logic [CW-1:0] occ       [NI];

    logic [DW-1:0] sb_q [NI][$];
    logic          prev_stall [NI];
    logic [DW-1:0] prev_data  [NI];
    int            rx_count   [NI];
    logic [DW-1:0] exp_beat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(1), .MODE(2), .CNT_WIDTH(CW)) u_m2s1 (
        .clk(clk), .reset(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .occupancy(occ[0]));

    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(3), .MODE(2), .CNT_WIDTH(CW)) u_m2s3 (
        .clk(clk), .reset(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .occupancy(occ[1]));

    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(2), .MODE(1), .CNT_WIDTH(CW)) u_m1s2 (
        .clk(clk), .reset(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .occupancy(occ[2]));

    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(2), .MODE(2), .CNT_WIDTH(CW)) u_m2s2 (
        .clk(clk), .reset(rst[3]), .in_data(in_data[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .out_data(out_data[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .occupancy(occ[3]));

    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(1), .MODE(0), .CNT_WIDTH(CW)) u_m0 (
        .clk(clk), .reset(rst[4]), .in_data(in_data[4]), .in_valid(in_valid[4]),
        .in_ready(in_ready[4]), .out_data(out_data[4]), .out_valid(out_valid[4]),
        .out_ready(out_ready[4]), .occupancy(occ[4]));

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, inst, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes seen at the negedge are the ones the next posedge commits.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                sb_q[i].delete();
                prev_stall[i] = 1'b0;
                rx_count[i]   = 0;
            end else begin
                check("occupancy_vs_model", i, 32'(occ[i]), 32'(sb_q[i].size()));
                if (prev_stall[i]) begin
                    check("stall_valid_hold", i, 32'(out_valid[i]), 32'd1);
                    check("stall_data_hold", i, 32'(out_data[i]), 32'(prev_data[i]));
                end
                if (in_valid[i] && in_ready[i]) begin
                    sb_q[i].push_back(in_data[i]);
                end
                if (out_valid[i] && out_ready[i]) begin
                    check("model_has_beat", i, 32'(sb_q[i].size() != 0), 32'd1);
                    if (sb_q[i].size() != 0) begin
                        exp_beat = sb_q[i].pop_front();
                        check("out_data_order", i, 32'(out_data[i]), 32'(exp_beat));
                        rx_count[i]++;
                    end
                end
                prev_stall[i] = out_valid[i] && !out_ready[i];
                prev_data[i]  = out_data[i];
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        int          last_acc;
        int          sent;
        int          cyc;
        logic [7:0]  mask;

        for (int i = 0; i < NI; i++) begin
            rst[i]       = 1'b1;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
        end

        // Reset state of every instance.
        repeat (2) next_cycle();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_out_valid", i, 32'(out_valid[i]), 32'd0);
            check("reset_in_ready", i, 32'(in_ready[i]), 32'd0);
            check("reset_occupancy", i, 32'(occ[i]), 32'd0);
        end
        next_cycle();
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);
        check("in_ready_first_cycle_after_reset", 0, 32'(in_ready[0]), 32'd0);
        next_cycle();
        @(negedge clk);
        check("in_ready_second_cycle_after_reset", 0, 32'(in_ready[0]), 32'd1);
        next_cycle();

        // MODE=2 STAGES=1: back-to-back stream with downstream always ready.
        out_ready[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = DW'(k);
            @(negedge clk);
            check("a_in_ready", 0, 32'(in_ready[0]), 32'd1);
            check("a_out_valid", 0, 32'(out_valid[0]), 32'(k != 0));
            check("a_occupancy", 0, 32'(occ[0]), (k != 0) ? 32'd1 : 32'd0);
            next_cycle();
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("a_last_valid", 0, 32'(out_valid[0]), 32'd1);
        check("a_last_data", 0, 32'(out_data[0]), 32'h9);
        next_cycle();
        @(negedge clk);
        check("a_empty_valid", 0, 32'(out_valid[0]), 32'd0);
        check("a_rx_count", 0, 32'(rx_count[0]), 32'd10);
        next_cycle();

        // MODE=2 STAGES=3: fill against a stalled sink, then drain.
        out_ready[1] = 1'b0;
        acc      = 0;
        last_acc = -1;
        for (int c = 0; c < 12; c++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = DW'(32'h100 + 32'(acc));
            @(negedge clk);
            if (in_ready[1]) begin
                acc++;
                last_acc = c;
            end
            next_cycle();
        end
        in_valid[1] = 1'b0;
        check("b_accept_count", 1, 32'(acc), 32'd6);
        check("b_last_accept_cycle", 1, 32'(last_acc), 32'd5);
        @(negedge clk);
        check("b_full_occupancy", 1, 32'(occ[1]), 32'd6);
        check("b_full_in_ready", 1, 32'(in_ready[1]), 32'd0);
        next_cycle();
        out_ready[1] = 1'b1;
        mask = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mask[c] = out_valid[1];
            next_cycle();
        end
        check("b_drain_pattern", 1, 32'(mask), 32'h3f);
        @(negedge clk);
        check("b_drained_occupancy", 1, 32'(occ[1]), 32'd0);
        next_cycle();

        // MODE=1 STAGES=2: full pipe, one-cycle pop lets a new beat in the same cycle.
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b1;
        in_data[2]   = DW'(32'h200);
        @(negedge clk);
        check("c_fill0_in_ready", 2, 32'(in_ready[2]), 32'd1);
        next_cycle();
        in_data[2] = DW'(32'h201);
        @(negedge clk);
        check("c_fill1_in_ready", 2, 32'(in_ready[2]), 32'd1);
        check("c_fill1_occupancy", 2, 32'(occ[2]), 32'd1);
        next_cycle();
        in_data[2] = DW'(32'h202);
        @(negedge clk);
        check("c_full_in_ready", 2, 32'(in_ready[2]), 32'd0);
        check("c_full_occupancy", 2, 32'(occ[2]), 32'd2);
        check("c_head_data", 2, 32'(out_data[2]), 32'h200);
        next_cycle();
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("c_pop_in_ready", 2, 32'(in_ready[2]), 32'd1);
        next_cycle();
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b0;
        @(negedge clk);
        check("c_refill_occupancy", 2, 32'(occ[2]), 32'd2);
        check("c_new_head_data", 2, 32'(out_data[2]), 32'h201);
        next_cycle();
        out_ready[2] = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("c_drained_occupancy", 2, 32'(occ[2]), 32'd0);
        check("c_rx_count", 2, 32'(rx_count[2]), 32'd3);
        next_cycle();

        // MODE=2 STAGES=2: random valid/ready, incrementing pattern.
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 40000) begin
            in_valid[3]  = 1'($urandom_range(0, 1));
            in_data[3]   = DW'(sent);
            out_ready[3] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid[3] && in_ready[3]) sent++;
            next_cycle();
            cyc++;
        end
        check("d_all_beats_sent", 3, 32'(sent), 32'd10000);
        in_valid[3]  = 1'b0;
        out_ready[3] = 1'b1;
        repeat (8) next_cycle();
        @(negedge clk);
        check("d_drained_occupancy", 3, 32'(occ[3]), 32'd0);
        check("d_model_drained", 3, 32'(sb_q[3].size()), 32'd0);
        check("d_rx_count", 3, 32'(rx_count[3]), 32'd10000);
        next_cycle();

        // MODE=2 STAGES=2: reset with four beats inside.
        out_ready[3] = 1'b0;
        acc = 0;
        for (int c = 0; c < 10 && acc < 4; c++) begin
            in_valid[3] = 1'b1;
            in_data[3]  = DW'(32'h300 + 32'(acc));
            @(negedge clk);
            if (in_ready[3]) acc++;
            next_cycle();
        end
        in_valid[3] = 1'b0;
        check("e_fill_count", 3, 32'(acc), 32'd4);
        @(negedge clk);
        check("e_full_occupancy", 3, 32'(occ[3]), 32'd4);
        next_cycle();
        rst[3] = 1'b1;
        @(negedge clk);
        check("e_in_ready_during_reset", 3, 32'(in_ready[3]), 32'd0);
        next_cycle();
        rst[3] = 1'b0;
        @(negedge clk);
        check("e_post_reset_out_valid", 3, 32'(out_valid[3]), 32'd0);
        check("e_post_reset_occupancy", 3, 32'(occ[3]), 32'd0);
        check("e_post_reset_in_ready", 3, 32'(in_ready[3]), 32'd0);
        next_cycle();
        out_ready[3] = 1'b1;
        @(negedge clk);
        check("e_in_ready_rises", 3, 32'(in_ready[3]), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("e_no_stale_beat", 3, 32'(out_valid[3]), 32'd0);
            next_cycle();
            @(negedge clk);
        end
        next_cycle();

        // MODE=0: combinational pass-through with toggling out_ready.
        in_valid[4] = 1'b1;
        in_data[4]  = DW'(32'ha5);
        for (int k = 0; k < 4; k++) begin
            out_ready[4] = 1'(k % 2);
            @(negedge clk);
            check("f_out_data", 4, 32'(out_data[4]), 32'ha5);
            check("f_out_valid", 4, 32'(out_valid[4]), 32'd1);
            check("f_in_ready", 4, 32'(in_ready[4]), 32'(k % 2));
            check("f_occupancy", 4, 32'(occ[4]), 32'd0);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
